// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush scheduler.
// The master side is the pipeline (drives hazard sources); the slave side is the scheduler.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_ex_flush;
    logic             id_ex_hold;
    logic             ex_mem_en;
    logic             mem_wait_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush,
               id_ex_hold, ex_mem_en, mem_wait_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               ex_redirect, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush,
               id_ex_hold, ex_mem_en, mem_wait_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, EX redirects,
// memory-wait freezes with a timeout watchdog, and saturating debug counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [15:0]      MAX_WAIT_L = 16'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    logic             err_q, err_d;

    logic load_use;
    logic mem_stall;
    logic freeze;

    assign load_use  = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                       ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                        (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
    assign mem_stall = hz.mem_req && !hz.mem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    wait_cnt_d = 16'd1;
                    state_d    = (MAX_WAIT_L <= 16'd1) ? ERR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_d >= MAX_WAIT_L) begin
                        state_d = ERR;
                    end
                end else begin
                    wait_cnt_d = 16'd0;
                    state_d    = RUN;
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outside a freeze a redirect squashes the ID instruction, so it beats load-use.
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.id_ex_hold   = 1'b0;
        hz.ex_mem_en    = 1'b1;
        if (reset) begin
            hz.pc_en      = 1'b0;
            hz.if_id_en   = 1'b0;
            hz.ex_mem_en  = 1'b0;
            hz.id_ex_hold = 1'b1;
        end else if (freeze) begin
            hz.pc_en      = 1'b0;
            hz.if_id_en   = 1'b0;
            hz.ex_mem_en  = 1'b0;
            hz.id_ex_hold = 1'b1;
        end else if (hz.ex_redirect) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (load_use) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        err_d          = (state_d == ERR);
        if (!hz.pc_en && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (hz.id_ex_flush && (flush_events_q != CNT_MAX)) begin
            flush_events_d = flush_events_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= 16'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            err_q          <= err_d;
        end
    end

    assign hz.mem_wait_err = err_q;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short watchdog (MAX_WAIT=4) and
// narrow counters (CNT_W=4) so timeout and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled mid-cycle.
    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt,
                                  input logic mrd, input logic [4:0] ert,
                                  input logic redir, input logic req,
                                  input logic rdy);
        hz.id_rs       = rs;
        hz.id_rt       = rt;
        hz.id_uses_rs  = urs;
        hz.id_uses_rt  = urt;
        hz.ex_mem_read = mrd;
        hz.ex_rt       = ert;
        hz.ex_redirect = redir;
        hz.mem_req     = req;
        hz.mem_ready   = rdy;
        #4;
    endtask

    task automatic idle_inputs();
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Packs {pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush, id_ex_hold, ex_mem_en}.
    function automatic logic [31:0] ctrl_vec();
        return {25'd0, hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_bubble,
                hz.id_ex_flush, hz.id_ex_hold, hz.ex_mem_en};
    endfunction

    localparam logic [31:0] C_NORMAL = 32'b1100001;
    localparam logic [31:0] C_FREEZE = 32'b0000010;
    localparam logic [31:0] C_BUBBLE = 32'b0001001;
    localparam logic [31:0] C_FLUSH  = 32'b1110101;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        #1;
        apply_stimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        check_output("reset_forced_outputs", ctrl_vec(), C_FREEZE);
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();
        check_output("reset_ctrl_normal", ctrl_vec(), C_NORMAL);
        check_output("reset_stall_cnt", 32'(hz.stall_cycles), 32'd0);
        check_output("reset_flush_cnt", 32'(hz.flush_events), 32'd0);
        check_output("reset_err", 32'(hz.mem_wait_err), 32'd0);

        // Load-use on rs, then on rt, then a non-reading rt.
        apply_stimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        check_output("load_use_rs", ctrl_vec(), C_BUBBLE);
        tick();
        idle_inputs();
        check_output("load_use_release", ctrl_vec(), C_NORMAL);
        check_output("load_use_stall_cnt", 32'(hz.stall_cycles), 32'd1);
        apply_stimulus(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        check_output("load_use_rt", ctrl_vec(), C_BUBBLE);
        tick();
        apply_stimulus(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        check_output("rt_not_used", ctrl_vec(), C_NORMAL);
        tick();
        check_output("load_use_stall_cnt2", 32'(hz.stall_cycles), 32'd2);

        // Load to $0 never stalls.
        do_reset();
        apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check_output("load_r0", ctrl_vec(), C_NORMAL);
        tick();
        check_output("load_r0_stall_cnt", 32'(hz.stall_cycles), 32'd0);

        // Redirect beats load-use.
        apply_stimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        check_output("redirect_vs_load_use", ctrl_vec(), C_FLUSH);
        tick();
        idle_inputs();
        check_output("redirect_flush_cnt", 32'(hz.flush_events), 32'd1);
        check_output("redirect_stall_cnt", 32'(hz.stall_cycles), 32'd0);

        // Three wait cycles, release, then a back-to-back wait.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("mem_wait_freeze_%0d", i), ctrl_vec(), C_FREEZE);
            tick();
        end
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_output("mem_wait_release", ctrl_vec(), C_NORMAL);
        tick();
        check_output("mem_wait_stall_cnt", 32'(hz.stall_cycles), 32'd3);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_output("back_to_back_freeze", ctrl_vec(), C_FREEZE);
        tick();
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_output("back_to_back_release", ctrl_vec(), C_NORMAL);
        tick();
        idle_inputs();
        check_output("back_to_back_run", ctrl_vec(), C_NORMAL);
        check_output("back_to_back_stall_cnt", 32'(hz.stall_cycles), 32'd4);

        // Redirect held across a 2-cycle wait is applied on release.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            check_output($sformatf("redirect_frozen_%0d", i), ctrl_vec(), C_FREEZE);
            tick();
        end
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check_output("redirect_on_release", ctrl_vec(), C_FLUSH);
        tick();
        idle_inputs();
        check_output("redirect_wait_flush_cnt", 32'(hz.flush_events), 32'd1);
        check_output("redirect_wait_stall_cnt", 32'(hz.stall_cycles), 32'd2);

        // Load-use pending across a wait gets its bubble on release.
        do_reset();
        apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        check_output("load_use_frozen", ctrl_vec(), C_FREEZE);
        tick();
        apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1);
        check_output("load_use_on_release", ctrl_vec(), C_BUBBLE);
        tick();
        idle_inputs();
        check_output("load_use_wait_stall_cnt", 32'(hz.stall_cycles), 32'd2);

        // Watchdog timeout after MAX_WAIT wait cycles, then counter saturation.
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++) begin
            apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("timeout_err_before_%0d", i),
                         32'(hz.mem_wait_err), 32'd0);
            tick();
        end
        check_output("timeout_err_set", 32'(hz.mem_wait_err), 32'd1);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check_output("err_stays_frozen", ctrl_vec(), C_FREEZE);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        idle_inputs();
        check_output("err_sticky", 32'(hz.mem_wait_err), 32'd1);
        check_output("err_frozen_idle", ctrl_vec(), C_FREEZE);
        check_output("stall_cnt_saturated", 32'(hz.stall_cycles), 32'd15);
        tick();
        check_output("stall_cnt_no_wrap", 32'(hz.stall_cycles), 32'd15);
        reset = 1'b1;
        idle_inputs();
        check_output("err_reset_forced", ctrl_vec(), C_FREEZE);
        tick();
        reset = 1'b0;
        idle_inputs();
        check_output("err_reset_ctrl", ctrl_vec(), C_NORMAL);
        check_output("err_reset_flag", 32'(hz.mem_wait_err), 32'd0);
        check_output("err_reset_stall_cnt", 32'(hz.stall_cycles), 32'd0);

        // Flush counter saturation via repeated redirects.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check_output("flush_cnt_saturated", 32'(hz.flush_events), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
